medevac_alarm_ctrl: RTL and testbench

- Parametrised successor of the medevac monitor FSM; takes N_SENS sensor lines and classifies each as critical or warning via CRIT_MASK.
- Adds per-channel debounce, latching critical with acknowledge/snooze re-alarm, first-fault capture and a sticky fault log.
- Sits between the sensor front-end and the alarm/annunciator outputs of the medevac unit.

---
 rtl/medevac_alarm_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_medevac_alarm_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/medevac_alarm_ctrl.sv
// Medevac alarm controller: debounced sensor classification, latching critical alarm with ack/snooze re-alarm.
// Optional escalation of long-lived warnings to CRITICAL is built when MEDEVAC_ESCALATE_EN is defined.
module medevac_alarm_ctrl #(
  parameter int                N_SENS     = 6,
  parameter logic [N_SENS-1:0] CRIT_MASK  = 6'b001111,
  parameter int                PERSIST    = 3,
  parameter int                SNOOZE_CYC = 64,
  parameter int                ESC_CYC    = 32,
  localparam int               FFW        = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_SENS-1:0] i_sens,
  input  logic              i_ack,
  output logic [1:0]        o_state,
  output logic              o_al,
  output logic              o_at,
  output logic              o_wrn,
  output logic [FFW-1:0]    o_first_fault,
  output logic [N_SENS-1:0] o_fault_vec,
  output logic [7:0]        o_realarm_cnt
);

  // state    | meaning
  // NORMAL   | no qualified fault
  // WARNING  | only warning-class channels qualified
  // CRITICAL | critical alarm latched, tone on until acknowledged
  // ACKED    | acknowledged, snooze running
  localparam logic [1:0] S_NORMAL   = 2'd0;
  localparam logic [1:0] S_WARNING  = 2'd1;
  localparam logic [1:0] S_CRITICAL = 2'd2;
  localparam logic [1:0] S_ACKED    = 2'd3;

  localparam int CW = $clog2(PERSIST + 1);
  localparam int SW = $clog2(SNOOZE_CYC);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [N_SENS-1:0] w_q;
  logic [N_SENS-1:0] w_crit_q;
  logic              w_crit;
  logic              w_warn;
  logic              w_new_crit;
  logic              w_snz_hit;
  logic              w_esc_hit;
  logic              w_realarm;
  logic              w_ff_load;
  logic              w_to_normal;
  logic [N_SENS-1:0] r_snap;
  logic [SW-1:0]     r_snz;
  logic [FFW-1:0]    r_first_fault;
  logic [N_SENS-1:0] r_fault_vec;
  logic [7:0]        r_realarm_cnt;

  for (genvar g = 0; g < N_SENS; g++) begin : g_deb
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else if (!i_sens[g]) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(PERSIST)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_q[g] = (r_cnt == CW'(PERSIST));
  end

  assign w_crit_q   = w_q & CRIT_MASK;
  assign w_crit     = |w_crit_q;
  assign w_warn     = |(w_q & ~CRIT_MASK);
  assign w_new_crit = |(w_crit_q & ~r_snap);
  assign w_snz_hit  = (r_snz == SW'(SNOOZE_CYC - 1));

`ifdef MEDEVAC_ESCALATE_EN
  localparam int EW = $clog2(ESC_CYC);
  logic [EW-1:0] r_esc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_esc <= '0;
    end else if (r_state == S_WARNING && w_next == S_WARNING) begin
      r_esc <= r_esc + 1'b1;
    end else begin
      r_esc <= '0;
    end
  end

  assign w_esc_hit = (r_esc == EW'(ESC_CYC - 1));
`else
  assign w_esc_hit = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_realarm = 1'b0;
    case (r_state)
      S_NORMAL: begin
        if (w_crit)      w_next = S_CRITICAL;
        else if (w_warn) w_next = S_WARNING;
      end
      S_WARNING: begin
        if (w_crit)         w_next = S_CRITICAL;
        else if (!w_warn)   w_next = S_NORMAL;
        else if (w_esc_hit) w_next = S_CRITICAL;
      end
      S_CRITICAL: begin
        if (i_ack) w_next = S_ACKED;
      end
      S_ACKED: begin
        // A channel that was not active at acknowledge time re-alarms at once.
        if (w_new_crit) begin
          w_next = S_CRITICAL;
        end else if (!w_crit) begin
          w_next = w_warn ? S_WARNING : S_NORMAL;
        end else if (w_snz_hit) begin
          w_next    = S_CRITICAL;
          w_realarm = 1'b1;
        end
      end
      default: w_next = S_NORMAL;
    endcase
  end

  function automatic logic [FFW-1:0] f_lowest(input logic [N_SENS-1:0] v);
    f_lowest = '0;
    for (int i = N_SENS - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = FFW'(i);
    end
  endfunction

  assign w_ff_load   = (w_next == S_CRITICAL) &&
                       (r_state == S_NORMAL || r_state == S_WARNING);
  assign w_to_normal = (w_next == S_NORMAL) && (r_state != S_NORMAL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_NORMAL;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snap <= '0;
      r_snz  <= '0;
    end else begin
      if (w_next == S_ACKED && r_state != S_ACKED) r_snap <= w_crit_q;
      if (r_state == S_ACKED && w_next == S_ACKED) r_snz <= r_snz + 1'b1;
      else                                         r_snz <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_first_fault <= '0;
    end else if (w_ff_load) begin
      // Escalated warnings have no critical bit set, so fall back to any qualified channel.
      r_first_fault <= w_crit ? f_lowest(w_crit_q) : f_lowest(w_q);
    end else if (w_to_normal) begin
      r_first_fault <= '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault_vec <= '0;
    end else if (w_to_normal) begin
      r_fault_vec <= '0;
    end else if (r_state != S_NORMAL || w_next != S_NORMAL) begin
      r_fault_vec <= r_fault_vec | w_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_realarm_cnt <= '0;
    end else if (w_realarm && r_realarm_cnt != 8'hFF) begin
      r_realarm_cnt <= r_realarm_cnt + 8'd1;
    end
  end

  assign o_state       = r_state;
  assign o_al          = (r_state == S_CRITICAL) || (r_state == S_ACKED);
  assign o_at          = (r_state == S_CRITICAL);
  assign o_wrn         = (r_state == S_WARNING);
  assign o_first_fault = r_first_fault;
  assign o_fault_vec   = r_fault_vec;
  assign o_realarm_cnt = r_realarm_cnt;

endmodule

// File: tb/tb_medevac_alarm_ctrl.sv
// Scoreboard bench for medevac_alarm_ctrl: directed stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them on their due cycle.
module tb_medevac_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sens;
  logic       ack;
  logic [1:0] state;
  logic       al, at, wrn;
  logic [2:0] first_fault;
  logic [5:0] fault_vec;
  logic [7:0] realarm_cnt;

  medevac_alarm_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sens        (sens),
    .i_ack         (ack),
    .o_state       (state),
    .o_al          (al),
    .o_at          (at),
    .o_wrn         (wrn),
    .o_first_fault (first_fault),
    .o_fault_vec   (fault_vec),
    .o_realarm_cnt (realarm_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          due;
    logic [21:0] val;
    logic [21:0] mask;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [21:0] M_ALL = 22'h3FFFFF;
  localparam logic [21:0] M_ST  = 22'h300000;

  function automatic logic [21:0] pk(input int st, input bit a_l, input bit a_t,
                                     input bit w, input int ff, input logic [5:0] fv,
                                     input int rc);
    logic [1:0] s2;
    logic [2:0] f3;
    logic [7:0] r8;
    s2 = st[1:0];
    f3 = ff[2:0];
    r8 = rc[7:0];
    return {s2, a_l, a_t, w, f3, fv, r8};
  endfunction

  task automatic expect_at(input string nm, input int d, input logic [21:0] v,
                           input logic [21:0] m);
    sb.push_back('{nm, cyc + d, v, m});
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] act;
    exp_t        e;
    act = {state, al, at, wrn, first_fault, fault_vec, realarm_cnt};
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
      end else if ((act & e.mask) !== (e.val & e.mask)) begin
        errors++;
        $display("FAIL %s: got %h required %h (mask %h) at cycle %0d",
                 e.name, act & e.mask, e.val & e.mask, e.mask, cyc);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    sens = '0;
    ack  = 1'b0;
    tick();
    expect_at("reset", 0, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    tick(2);
    rst = 1'b0;
    tick(2);

    // short pulse never qualifies
    sens = 6'b100000;
    tick(2);
    sens = 6'b000000;
    expect_at("deb_short", 3, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    tick(4);

    // held warning channel qualifies on the 4th edge
    sens = 6'b100000;
    expect_at("deb_pre", 3, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    expect_at("deb_warn", 4, pk(1, 0, 0, 1, 0, 6'b100000, 0), M_ALL);
    tick(10);
    sens = 6'b000000;
    expect_at("warn_hold", 1, pk(1, 0, 0, 1, 0, 6'b100000, 0), M_ALL);
    expect_at("warn_exit", 2, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    tick(3);

    // latching critical and acknowledge
    sens = 6'b001000;
    expect_at("crit_entry", 4, pk(2, 1, 1, 0, 3, 6'b001000, 0), M_ALL);
    tick(6);
    sens = 6'b000000;
    expect_at("crit_latch", 3, pk(2, 1, 1, 0, 3, 6'b001000, 0), M_ALL);
    tick(3);
    ack = 1'b1;
    expect_at("ack_acked", 1, pk(3, 1, 0, 0, 3, 6'b001000, 0), M_ALL);
    expect_at("ack_to_normal", 2, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    tick();
    ack = 1'b0;
    tick(3);

    // snooze expiry and saturating re-alarm count
    sens = 6'b000100;
    expect_at("snz_crit", 4, pk(2, 1, 1, 0, 2, 6'b000100, 0), M_ALL);
    tick(5);
    for (int k = 1; k <= 300; k++) begin
      int rc;
      rc  = (k > 255) ? 255 : k;
      ack = 1'b1;
      if (k == 1) begin
        expect_at("snz_acked", 1, pk(3, 1, 0, 0, 2, 6'b000100, 0), M_ALL);
        expect_at("snz_still", 64, pk(3, 1, 0, 0, 2, 6'b000100, 0), M_ALL);
      end
      if (k == 1 || k == 2 || k == 254 || k == 255 || k == 256 || k == 300)
        expect_at($sformatf("snz_realarm_%0d", k), 65, pk(2, 1, 1, 0, 2, 6'b000100, rc), M_ALL);
      tick();
      ack = 1'b0;
      tick(64);
    end

    // new critical channel while acknowledged
    ack = 1'b1;
    tick();
    ack = 1'b0;
    sens = 6'b000101;
    expect_at("newf_pre", 3, pk(3, 1, 0, 0, 2, 6'b000100, 255), M_ALL);
    expect_at("newf_crit", 4, pk(2, 1, 1, 0, 2, 6'b000101, 255), M_ALL);
    tick(5);
    sens = 6'b000100;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    sens = 6'b000101;
    tick(3);
    ack = 1'b1;
    expect_at("newf_ack", 1, pk(2, 1, 1, 0, 2, 6'b000101, 255), M_ALL);
    tick();
    ack = 1'b0;

    // return to NORMAL; realarm count survives
    sens = 6'b000000;
    tick();
    ack = 1'b1;
    expect_at("clr_normal", 2, pk(0, 0, 0, 0, 0, 6'b000000, 255), M_ALL);
    tick();
    ack = 1'b0;
    tick(3);

    // long-lived warning
    sens = 6'b010000;
    expect_at("esc_warn", 35, pk(1, 0, 0, 1, 0, 6'b010000, 255), M_ALL);
`ifdef MEDEVAC_ESCALATE_EN
    expect_at("esc_crit", 36, pk(2, 1, 1, 0, 4, 6'b010000, 255), M_ALL);
`else
    expect_at("esc_none", 36, pk(1, 0, 0, 1, 0, 6'b010000, 255), M_ALL);
`endif
    tick(40);
    sens = 6'b000000;
    tick(3);

    // asynchronous reset between edges
    sens = 6'b001000;
    tick(6);
    expect_at("rst_pre", 0, pk(2, 0, 0, 0, 0, 6'b000000, 0), M_ST);
    tick();
    #1;
    rst = 1'b1;
    expect_at("rst_async", 0, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    tick();
    rst = 1'b0;
    expect_at("rst_rel_pre", 3, pk(0, 0, 0, 0, 0, 6'b000000, 0), M_ALL);
    expect_at("rst_rel_crit", 4, pk(2, 1, 1, 0, 3, 6'b001000, 0), M_ALL);
    tick(6);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared (due %0d, now %0d)", e.name, e.due, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
